fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 9 +
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit_sync_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline defines: datapath width and sequential instruction step.
package fetch_unit_pkg;
  localparam int XLEN       = 32;
  localparam int INSTR_STEP = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: instruction-memory request/response, redirect and IF->ID handoff.
interface fetch_unit_if #(parameter int WORD_WIDTH = fetch_unit_pkg::XLEN);
  logic                  imem_req;
  logic [WORD_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [WORD_WIDTH-1:0] imem_rdata;
  logic                  redirect_valid;
  logic [WORD_WIDTH-1:0] redirect_addr;
  logic                  id_ready;
  logic                  if_valid;
  logic [WORD_WIDTH-1:0] if_instr;
  logic [WORD_WIDTH-1:0] if_pc_nxt;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc_nxt,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_addr, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc_nxt,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_addr, id_ready
  );
endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO with flush; registered storage, head visible the cycle after push.
// Push while full is accepted only together with a pop.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/fetch_unit.sv
// Credit-limited instruction prefetcher: PC, in-order response tracking, prefetch queue.
// Responses reach if_valid one cycle after imem_rvalid; redirect flushes and drops in-flight words.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    WORD_WIDTH = XLEN,
  parameter int                    DEPTH      = 4,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master fu
);
  localparam int                    CW      = cnt_width(DEPTH);
  localparam logic [CW:0]           DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [WORD_WIDTH-1:0] STEP    = WORD_WIDTH'(INSTR_STEP);

  logic [WORD_WIDTH-1:0]   pc_q, pc_d;
  logic [WORD_WIDTH-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]           outst_q, outst_d;
  logic [CW-1:0]           disc_q, disc_d;
  logic [CW-1:0]           fifo_count;
  logic [CW:0]             in_use;
  logic                    issue, rsp_drop, rsp_keep;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*WORD_WIDTH-1:0] fifo_rdata;
  logic [WORD_WIDTH-1:0]   head_pc, head_instr;

  // Credit is taken from registered state only, so imem_req never sees rvalid/id_ready.
  assign in_use = {1'b0, fifo_count} + {1'b0, outst_q};
  assign issue  = !rst && !fu.redirect_valid && (in_use < DEPTH_C);

  assign rsp_drop  = fu.imem_rvalid && (fu.redirect_valid || disc_q != '0);
  assign rsp_keep  = fu.imem_rvalid && !rsp_drop;
  assign fifo_push = rsp_keep && (!fifo_full || fifo_pop);
  assign fifo_pop  = !fifo_empty && fu.id_ready && !fu.redirect_valid;

  assign fu.imem_req  = issue;
  assign fu.imem_addr = rst ? '0 : pc_q;

  assign {head_pc, head_instr} = fifo_rdata;
  assign fu.if_valid  = !fifo_empty;
  assign fu.if_instr  = fifo_empty ? '0 : head_instr;
  assign fu.if_pc_nxt = fifo_empty ? '0 : head_pc + STEP;

  // rsp_pc_q is the fetch address of the next response that will be kept.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q;
    disc_d   = disc_q;
    if (issue) pc_d = pc_q + STEP;
    case ({issue, fu.imem_rvalid})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: ;
    endcase
    if (rsp_keep) rsp_pc_d = rsp_pc_q + STEP;
    else if (rsp_drop && disc_q != '0) disc_d = disc_q - 1'b1;
    if (fu.redirect_valid) begin
      pc_d     = fu.redirect_addr;
      rsp_pc_d = fu.redirect_addr;
      disc_d   = outst_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      disc_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
    end
  end

  sync_fifo #(
    .WIDTH (2*WORD_WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fu.redirect_valid),
    .wdata_i ({rsp_pc_q, fu.imem_rdata}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-level model of fetch, flush and delivery.
module tb_fetch_unit;
  localparam int             W   = 32;
  localparam int             D   = 4;
  localparam logic [W-1:0]   RPC = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if #(.WORD_WIDTH(W)) bus();

  fetch_unit #(.WORD_WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .fu  (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] addr; bit stale; }            infl_t;
  typedef struct { logic [W-1:0] addr; logic [W-1:0] instr; }  ent_t;
  typedef struct { logic [W-1:0] addr; int due; }              pend_t;

  infl_t        infl[$];
  ent_t         mq[$];
  pend_t        pend[$];
  logic [W-1:0] fpc;
  int           cyc = 0;
  int           last_due;
  int           lat_min, lat_max;
  int           checks = 0;
  int           errors = 0;

  logic         o_req, o_valid, o_rvalid;
  logic [W-1:0] o_addr, o_instr, o_pcnxt;

  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] memf(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input bit check_now);
    rst = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.id_ready       = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_imem_req",  bus.imem_req,  '0);
      chk("rst_imem_addr", bus.imem_addr, '0);
      chk("rst_if_valid",  bus.if_valid,  '0);
      chk("rst_if_instr",  bus.if_instr,  '0);
      chk("rst_if_pc_nxt", bus.if_pc_nxt, '0);
    end
    infl.delete();
    mq.delete();
    pend.delete();
    fpc      = RPC;
    last_due = -1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: drive inputs, compare at negedge, advance model across the edge.
  task automatic step(input bit rdr, input logic [W-1:0] raddr, input bit rdy);
    bit           exp_req;
    logic [W-1:0] rsp_addr;
    int           due;
    infl_t        e;
    bus.redirect_valid = rdr;
    bus.redirect_addr  = raddr;
    bus.id_ready       = rdy;
    rsp_addr           = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rsp_addr        = pend[0].addr;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memf(rsp_addr);
      void'(pend.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end

    @(negedge clk);
    exp_req  = ((mq.size() + infl.size()) < D) && !rdr;
    o_req    = bus.imem_req;
    o_addr   = bus.imem_addr;
    o_valid  = bus.if_valid;
    o_instr  = bus.if_instr;
    o_pcnxt  = bus.if_pc_nxt;
    o_rvalid = bus.imem_rvalid;
    chk("imem_req", o_req, exp_req);
    if (exp_req) chk("imem_addr", o_addr, fpc);
    chk("if_valid", o_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("if_instr",  o_instr, mq[0].instr);
      chk("if_pc_nxt", o_pcnxt, mq[0].addr + 32'd4);
    end

    if (o_req) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      pend.push_back('{addr: o_addr, due: due});
      last_due = due;
    end

    if (o_rvalid && infl.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_without_request actual=response required=none");
    end
    if (rdr) begin
      if (o_rvalid && infl.size() > 0) void'(infl.pop_front());
      foreach (infl[i]) infl[i].stale = 1'b1;
      mq.delete();
      fpc = raddr;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (o_rvalid && infl.size() > 0) begin
        e = infl.pop_front();
        if (!e.stale) mq.push_back('{addr: e.addr, instr: memf(e.addr)});
      end
      if (exp_req) begin
        infl.push_back('{addr: fpc, stale: 1'b0});
        fpc = fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] seen[3];
    int           first_v, nreq, bad, found;
    logic [W-1:0] first_pcnxt, first_instr;

    // Reset, latency 1, always ready: sequential fetch from RESET_PC.
    lat_min = 1; lat_max = 1;
    do_reset(1'b1);
    first_v = -1; first_pcnxt = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1);
      if (i < 3) seen[i] = o_req ? o_addr : 32'hDEAD_BEEF;
      if (o_valid && first_v < 0) begin first_v = i; first_pcnxt = o_pcnxt; end
    end
    chk("seq_addr0", seen[0], 32'h0);
    chk("seq_addr1", seen[1], 32'h4);
    chk("seq_addr2", seen[2], 32'h8);
    chk("seq_first_valid_cycle", W'(first_v), 32'd2);
    chk("seq_first_pc_nxt", first_pcnxt, 32'h4);

    // Stall: exactly DEPTH requests, then one refill per pop.
    do_reset(1'b0);
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, 1'b0);
      if (o_req) nreq++;
    end
    chk("stall_req_count", W'(nreq), 32'd4);
    chk("stall_req_idle", o_req, '0);
    chk("stall_head_valid", o_valid, 32'h1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("stall_refill_after_pop", o_req, 32'h1);
    step(1'b0, '0, 1'b0);
    chk("stall_one_per_pop", o_req, '0);

    // Latency 3, redirect with three outstanding.
    lat_min = 3; lat_max = 3;
    do_reset(1'b0);
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    found = 0; first_instr = '0; first_pcnxt = '0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1'b0, '0, 1'b1);
      if (o_valid) begin found = 1; first_instr = o_instr; first_pcnxt = o_pcnxt; end
    end
    chk("redir_found", W'(found), 32'd1);
    chk("redir_first_instr", first_instr, memf(32'h100));
    chk("redir_first_pc_nxt", first_pcnxt, 32'h104);

    // Redirect colliding with a response and a pop.
    lat_min = 1; lat_max = 1;
    do_reset(1'b0);
    repeat (5) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h180, 1'b1);
    chk("collide_pre_rvalid", o_rvalid, 32'h1);
    chk("collide_pre_valid", o_valid, 32'h1);
    step(1'b0, '0, 1'b1);
    chk("collide_queue_empty", o_valid, '0);
    chk("collide_req", o_req, 32'h1);
    chk("collide_addr", o_addr, 32'h180);

    // Back-to-back redirects.
    lat_min = 3; lat_max = 3;
    do_reset(1'b0);
    repeat (2) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h200, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'h300, 1'b1);
    bad = 0; found = 0; first_pcnxt = '0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, '0, 1'b1);
      if (o_valid && o_pcnxt >= 32'h200 && o_pcnxt < 32'h300) bad++;
      if (o_valid && found == 0) begin found = 1; first_pcnxt = o_pcnxt; end
    end
    chk("b2b_no_0x200_path", W'(bad), '0);
    chk("b2b_first_pc_nxt", first_pcnxt, 32'h304);

    // Reset with outstanding requests and a partly filled queue.
    lat_min = 2; lat_max = 2;
    do_reset(1'b0);
    repeat (4) step(1'b0, '0, 1'b0);
    do_reset(1'b1);
    lat_min = 1; lat_max = 1;
    step(1'b0, '0, 1'b1);
    chk("rst_restart_req", o_req, 32'h1);
    chk("rst_restart_addr", o_addr, RPC);
    repeat (8) step(1'b0, '0, 1'b1);

    // Address wrap at the top of the space.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("wrap_addr0", o_addr, 32'hFFFF_FFF8);
    step(1'b0, '0, 1'b1);
    chk("wrap_addr1", o_addr, 32'hFFFF_FFFC);
    step(1'b0, '0, 1'b1);
    chk("wrap_addr2", o_addr, 32'h0);
    repeat (6) step(1'b0, '0, 1'b1);

    // Random traffic: variable latency, stalls, redirects, one mid-run reset.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      logic [W-1:0] ra;
      if (i == 400) do_reset(1'b1);
      ra = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                       : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 19) == 0, ra, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
